// File: rtl/brisc_pkg.sv
// Shared BRISC types and widths: request control/size encodings, address and data widths,
// and the default store buffer depth.
package brisc_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int XLEN          = 32;
    localparam int STB_DEPTH     = 4;

    typedef enum logic [1:0] {
        IS_STORE = 2'd0,
        IS_LOAD  = 2'd1,
        OTHER    = 2'd2
    } stb_ctrl_e;

    typedef enum logic {
        B = 1'b0,
        W = 1'b1
    } data_size_e;

endpackage

// File: rtl/brisc_stb_match.sv
// Per-entry address compare against a load, with youngest-match priority select.
// any_word_o flags any live entry in the same word; hit_o/idx_o name the youngest usable source.
module brisc_stb_match
    import brisc_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH,
    parameter int AW    = ADDRESS_WIDTH
) (
    input  logic [$clog2(DEPTH)-1:0] rd_ptr_i,
    input  logic [$clog2(DEPTH):0]   count_i,
    input  logic [AW-1:0]            entry_addr_i [DEPTH],
    input  data_size_e               entry_size_i [DEPTH],
    input  logic [AW-1:0]            ld_addr_i,
    input  data_size_e               ld_size_i,
    output logic                     any_word_o,
    output logic                     hit_o,
    output logic [$clog2(DEPTH)-1:0] idx_o
);

    logic [$clog2(DEPTH)-1:0] idx;
    logic                     word_eq;

    // Walk from oldest to youngest so the last match written wins.
    always_comb begin
        any_word_o = 1'b0;
        hit_o      = 1'b0;
        idx_o      = rd_ptr_i;
        idx        = '0;
        word_eq    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx     = rd_ptr_i + k[$clog2(DEPTH)-1:0];
            word_eq = (entry_addr_i[idx][AW-1:2] == ld_addr_i[AW-1:2]);
            if (k < int'(count_i) && word_eq) begin
                any_word_o = 1'b1;
                if (ld_size_i == W || entry_size_i[idx] == W ||
                    entry_addr_i[idx][1:0] == ld_addr_i[1:0]) begin
                    hit_o = 1'b1;
                    idx_o = idx;
                end
            end
        end
    end

endmodule

// File: rtl/brisc_store_buffer.sv
// Circular store buffer between the memory stage and the data cache, with load lookup.
// Macro BRISC_STB_FWD_EN enables store-to-load forwarding; otherwise matching loads stall.
module brisc_store_buffer
    import brisc_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH,
    parameter int AW    = ADDRESS_WIDTH,
    parameter int DW    = XLEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid_i,
    input  stb_ctrl_e              req_ctrl_i,
    input  logic [AW-1:0]          req_addr_i,
    input  logic [DW-1:0]          req_data_i,
    input  data_size_e             req_size_i,
    output logic                   stall_o,
    output logic                   ld_hit_o,
    output logic [DW-1:0]          ld_data_o,
    output logic                   drain_valid_o,
    output logic [AW-1:0]          drain_addr_o,
    output logic [DW-1:0]          drain_data_o,
    output data_size_e             drain_size_o,
    input  logic                   drain_ready_i,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    data_size_e    size_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic store_req, load_req, full, enq, pop, load_stall;
    logic m_any, m_hit;
    logic [PW-1:0] m_idx;

    assign store_req = req_valid_i && (req_ctrl_i == IS_STORE);
    assign load_req  = req_valid_i && (req_ctrl_i == IS_LOAD);
    assign full      = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign enq       = store_req && !full;

    // Drain handshake: the oldest entry is offered while drain_valid_o is high and its
    // fields hold steady; it leaves the buffer on any edge where drain_ready_i is also high.
    // Reset masks valid so no handshake can complete in the reset cycle.
    assign drain_valid_o = !empty_o && !reset;
    assign pop           = drain_valid_o && drain_ready_i;
    assign drain_addr_o  = addr_q[rd_ptr_q];
    assign drain_data_o  = data_q[rd_ptr_q];
    assign drain_size_o  = size_q[rd_ptr_q];

    brisc_stb_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
        .rd_ptr_i     (rd_ptr_q),
        .count_i      (count_q),
        .entry_addr_i (addr_q),
        .entry_size_i (size_q),
        .ld_addr_i    (req_addr_i),
        .ld_size_i    (req_size_i),
        .any_word_o   (m_any),
        .hit_o        (m_hit),
        .idx_o        (m_idx)
    );

`ifdef BRISC_STB_FWD_EN
    logic          partial, unused_match;
    logic [DW-1:0] src_data, lane;

    // A byte store cannot supply a whole word, so the load waits for it to drain.
    assign partial      = m_hit && (req_size_i == W) && (size_q[m_idx] == B);
    assign src_data     = data_q[m_idx];
    assign lane         = (size_q[m_idx] == W) ? (src_data >> {req_addr_i[1:0], 3'b000}) : src_data;
    assign load_stall   = load_req && partial;
    assign ld_hit_o     = load_req && m_hit && !partial;
    assign ld_data_o    = !ld_hit_o ? '0 :
                          (req_size_i == W) ? src_data : {{(DW-8){1'b0}}, lane[7:0]};
    assign unused_match = m_any;
`else
    logic unused_match;

    assign load_stall   = load_req && m_any;
    assign ld_hit_o     = 1'b0;
    assign ld_data_o    = '0;
    assign unused_match = ^{m_hit, m_idx};
`endif

    assign stall_o = (store_req && full) || load_stall;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(enq);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(enq) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= req_addr_i;
            data_q[wr_ptr_q] <= req_data_i;
            size_q[wr_ptr_q] <= req_size_i;
        end
    end

endmodule
